ftdi_fifo_arb: RTL and testbench
================================

Name: ftdi_fifo_arb

Overview:
Arbiter and sequencer for the shared FT245R 8-bit FIFO bus. It sits between the inner memory-map logic and the FT245 read and write sequencers. It decides which sequencer owns the bus, pulses that sequencer's activate line, and waits for its done strobe. It controls data-bus drive direction with a turnaround gap, and buffers received bytes in a small RX FIFO and one pending TX byte.

Parameters:
RX_AW, 2, RX FIFO address width; depth = 2**RX_AW bytes.
TURN_CYC, 2, idle clocks inserted before the bus changes direction (1..15).

Ports:
clk  input  1  system clock, 50 MHz
rst  input  1  asynchronous reset, active-low
oRX_DATA  output  8  RX FIFO head byte
oRX_VALID  output  1  RX FIFO not empty
iRX_READY  input  1  inner logic pops head when oRX_VALID=1 and iRX_READY=1
iTX_DATA  input  8  byte to transmit
iTX_VALID  input  1  TX byte offered
oTX_READY  output  1  TX holding register empty
oACT_RD_n  output  1  read sequencer activate, 1-cycle low pulse
iREADY_RD_n  input  1  read sequencer idle (low)
iDONE_RD_n  input  1  read sequencer done strobe (low)
iRD_DATA  input  8  read sequencer captured byte
oACT_WR_n  output  1  write sequencer activate, 1-cycle low pulse
iREADY_WR_n  input  1  write sequencer idle (low)
iDONE_WR_n  input  1  write sequencer done strobe (low)
oWR_DATA  output  8  byte presented to write sequencer
iFIFO_RXF_n  input  1  FT245 RX data available (low)
iFIFO_TXE_n  input  1  FT245 TX space available (low)
oBUS_OE  output  1  1 = FPGA drives FT245 data pins

Behaviour:
- Reset (async, rst=0), mid-operation included: state=IDLE; all grants, FIFO pointers and count cleared; last_grant=WR, so the first tie goes to RD; last_dir=RD; turn counter=0.
  - Output reset values: oACT_RD_n=1, oACT_WR_n=1, oWR_DATA=0, oBUS_OE=0, oRX_VALID=0, oRX_DATA=0, oTX_READY=1.
- Eligibility, evaluated in IDLE only:
  - rd_ok = !iFIFO_RXF_n & !iREADY_RD_n & (rx_count < 2**RX_AW).
  - wr_ok = tx_full & !iFIFO_TXE_n & !iREADY_WR_n.
- Grant rule:
  - Only one eligible: that side is granted.
  - Both eligible: the side opposite last_grant is granted (round-robin).
  - last_grant is updated on each grant.
- States:
  - IDLE: on grant, if the granted direction equals last_dir go to the side's ACT state; otherwise load the turn counter with TURN_CYC and go to TURN.
  - TURN: oBUS_OE=0; count down; at 0 set last_dir to the granted side and go to its ACT state. Eligibility is not re-checked.
  - RD_ACT: oACT_RD_n=0 for exactly 1 cycle; go to RD_WAIT.
  - RD_WAIT: when iDONE_RD_n=0, push iRD_DATA into the RX FIFO and return to IDLE.
  - WR_ACT: oBUS_OE=1; oACT_WR_n=0 for 1 cycle; go to WR_WAIT.
  - WR_WAIT: oBUS_OE=1; when iDONE_WR_n=0, clear tx_full and go to IDLE.
  - oBUS_OE stays 1 in IDLE while last_dir=WR. It drops only in TURN.
- Latency:
  - Grant to ACT with no turnaround: 1 clock.
  - Push to oRX_VALID=1: the clock after the iDONE_RD_n=0 sample.
- No timeout: a sequencer in its RXF/TXE wait holds the grant indefinitely.
- TX holding register:
  - Accept when iTX_VALID & oTX_READY; oTX_READY = !tx_full (combinational).
  - oWR_DATA is registered at accept and held stable until the next accept.
- RX FIFO:
  - Push only as above. Overflow is impossible: grant requires space and only one read is ever outstanding.
  - Pop on oRX_VALID & iRX_READY. A pop while empty is ignored.
  - Push and pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo 2**RX_AW.
- Done strobes arriving outside the matching WAIT state are ignored.

Test Plan:
- Read burst: RXF_n=0, iRX_READY=0, RX_AW=2, read model returns 0x11,0x22,0x33,0x44,0x55 -> 4 RX grants; 5th read not started (full); oRX_VALID=1, head=0x11; after 1 pop the 5th read starts and 0x55 is queued last.
- Single TX: last_dir=WR, TXE_n=0, offer 0xA5 -> oTX_READY falls next cycle, oACT_WR_n low 1 cycle, oWR_DATA=0xA5 with oBUS_OE=1 through done; oTX_READY=1 after iDONE_WR_n.
- Contention: RXF_n=0, TXE_n=0, TX pending continuously -> grants alternate RD,WR,RD,WR; each direction change shows oBUS_OE=0 for TURN_CYC=2 clocks before ACT.
- Simultaneous push/pop at count=2 -> count stays 2, order preserved.
- Reset asserted in WR_WAIT with oBUS_OE=1 -> oBUS_OE=0, oACT_*_n=1, oRX_VALID=0, oTX_READY=1 immediately (asynchronously).
- Stray iDONE_WR_n=0 pulse while in IDLE -> no state change, tx_full unchanged.

Source files
------------

// File: rtl/ftdi_fifo_arb_if.sv
// ftdi_fifo_arb_if
// Bundles every handshake and bus signal around the FT245R FIFO-bus arbiter.
//   master : the arbiter (drives activates, RX FIFO head, TX ready, bus OE)
//   slave  : the surroundings (inner logic, read/write sequencers, FT245 flags)
// Port groups:
//   RX stream   : oRX_DATA, oRX_VALID, iRX_READY
//   TX stream   : iTX_DATA, iTX_VALID, oTX_READY
//   read seq    : oACT_RD_n, iREADY_RD_n, iDONE_RD_n, iRD_DATA
//   write seq   : oACT_WR_n, iREADY_WR_n, iDONE_WR_n, oWR_DATA
//   FT245 flags : iFIFO_RXF_n, iFIFO_TXE_n; bus direction oBUS_OE
interface ftdi_fifo_arb_if;
  logic [7:0] oRX_DATA;
  logic       oRX_VALID;
  logic       iRX_READY;
  logic [7:0] iTX_DATA;
  logic       iTX_VALID;
  logic       oTX_READY;
  logic       oACT_RD_n;
  logic       iREADY_RD_n;
  logic       iDONE_RD_n;
  logic [7:0] iRD_DATA;
  logic       oACT_WR_n;
  logic       iREADY_WR_n;
  logic       iDONE_WR_n;
  logic [7:0] oWR_DATA;
  logic       iFIFO_RXF_n;
  logic       iFIFO_TXE_n;
  logic       oBUS_OE;

  modport master (
    output oRX_DATA, oRX_VALID, oTX_READY, oACT_RD_n, oACT_WR_n, oWR_DATA, oBUS_OE,
    input  iRX_READY, iTX_DATA, iTX_VALID, iREADY_RD_n, iDONE_RD_n, iRD_DATA,
           iREADY_WR_n, iDONE_WR_n, iFIFO_RXF_n, iFIFO_TXE_n
  );

  modport slave (
    input  oRX_DATA, oRX_VALID, oTX_READY, oACT_RD_n, oACT_WR_n, oWR_DATA, oBUS_OE,
    output iRX_READY, iTX_DATA, iTX_VALID, iREADY_RD_n, iDONE_RD_n, iRD_DATA,
           iREADY_WR_n, iDONE_WR_n, iFIFO_RXF_n, iFIFO_TXE_n
  );
endinterface

// File: rtl/ftdi_fifo_arb.sv
// ftdi_fifo_arb
// Owns the shared FT245R data bus: picks the read or write sequencer
// (round-robin on ties), pulses its activate, waits for its done strobe,
// inserts TURN_CYC idle clocks whenever the bus changes direction, buffers
// received bytes in a 2**RX_AW deep FIFO and holds one pending TX byte.
// Ports:
//   clk : system clock
//   rst : asynchronous reset, active low
//   bus : ftdi_fifo_arb_if.master (all stream, sequencer and FT245 signals)
module ftdi_fifo_arb #(
  parameter int unsigned RX_AW    = 2,
  parameter int unsigned TURN_CYC = 2
) (
  input  logic             clk,
  input  logic             rst,
  ftdi_fifo_arb_if.master  bus
);
  localparam int unsigned      DEPTH    = 1 << RX_AW;
  localparam logic [RX_AW:0]   RX_FULL  = {1'b1, {RX_AW{1'b0}}};
  localparam logic [3:0]       TURN_LD  = 4'(TURN_CYC);

  typedef enum logic [2:0] {IDLE, TURN, RD_ACT, RD_WAIT, WR_ACT, WR_WAIT} state_e;
  typedef enum logic {SIDE_RD, SIDE_WR} side_e;

  state_e           state_q, state_d;
  side_e            last_grant_q, last_grant_d;
  side_e            last_dir_q, last_dir_d;
  side_e            grant_q, grant_d;
  logic [3:0]       turn_cnt_q, turn_cnt_d;
  logic             act_rd_n_q, act_rd_n_d;
  logic             act_wr_n_q, act_wr_n_d;
  logic             bus_oe_q, bus_oe_d;
  logic             tx_full_q, tx_full_d;
  logic [7:0]       wr_data_q, wr_data_d;
  logic [RX_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [RX_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [RX_AW:0]   rx_count_q, rx_count_d;
  logic [7:0]       rx_mem [DEPTH];

  logic rd_ok, wr_ok, rx_push, rx_pop, tx_accept;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_d      = state_q;
    last_grant_d = last_grant_q;
    last_dir_d   = last_dir_q;
    grant_d      = grant_q;
    turn_cnt_d   = turn_cnt_q;
    tx_full_d    = tx_full_q;
    wr_data_d    = wr_data_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    rx_count_d   = rx_count_q;

    rd_ok     = !bus.iFIFO_RXF_n && !bus.iREADY_RD_n && (rx_count_q != RX_FULL);
    wr_ok     = tx_full_q && !bus.iFIFO_TXE_n && !bus.iREADY_WR_n;
    tx_accept = bus.iTX_VALID && !tx_full_q;
    rx_pop    = (rx_count_q != '0) && bus.iRX_READY;
    rx_push   = (state_q == RD_WAIT) && !bus.iDONE_RD_n;

    unique case (state_q)
      IDLE: begin
        if (rd_ok || wr_ok) begin
          // Ties go to the side that did not win last time.
          grant_d      = (rd_ok && (!wr_ok || last_grant_q == SIDE_WR)) ? SIDE_RD : SIDE_WR;
          last_grant_d = grant_d;
          if (grant_d == last_dir_q) begin
            state_d = (grant_d == SIDE_RD) ? RD_ACT : WR_ACT;
          end else begin
            turn_cnt_d = TURN_LD;
            state_d    = TURN;
          end
        end
      end
      TURN: begin
        // Eligibility is deliberately not re-checked: the grant is committed.
        turn_cnt_d = turn_cnt_q - 4'd1;
        if (turn_cnt_q <= 4'd1) begin
          last_dir_d = grant_q;
          state_d    = (grant_q == SIDE_RD) ? RD_ACT : WR_ACT;
        end
      end
      RD_ACT:  state_d = RD_WAIT;
      RD_WAIT: if (!bus.iDONE_RD_n) state_d = IDLE;
      WR_ACT:  state_d = WR_WAIT;
      WR_WAIT: begin
        if (!bus.iDONE_WR_n) begin
          tx_full_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Accept and release are mutually exclusive: one needs tx_full low, the other high.
    if (tx_accept) begin
      tx_full_d = 1'b1;
      wr_data_d = bus.iTX_DATA;
    end

    if (rx_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rx_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (rx_push && !rx_pop)      rx_count_d = rx_count_q + 1'b1;
    else if (!rx_push && rx_pop) rx_count_d = rx_count_q - 1'b1;

    // Outputs are derived from the next state so they are glitch-free flops
    // that line up with the state they belong to.
    act_rd_n_d = (state_d != RD_ACT);
    act_wr_n_d = (state_d != WR_ACT);
    bus_oe_d   = (state_d == WR_ACT) || (state_d == WR_WAIT) ||
                 ((state_d == IDLE) && (last_dir_d == SIDE_WR));
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= SIDE_WR;
      last_dir_q   <= SIDE_RD;
      grant_q      <= SIDE_RD;
      turn_cnt_q   <= '0;
      act_rd_n_q   <= 1'b1;
      act_wr_n_q   <= 1'b1;
      bus_oe_q     <= 1'b0;
      tx_full_q    <= 1'b0;
      wr_data_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      rx_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      last_dir_q   <= last_dir_d;
      grant_q      <= grant_d;
      turn_cnt_q   <= turn_cnt_d;
      act_rd_n_q   <= act_rd_n_d;
      act_wr_n_q   <= act_wr_n_d;
      bus_oe_q     <= bus_oe_d;
      tx_full_q    <= tx_full_d;
      wr_data_q    <= wr_data_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      rx_count_q   <= rx_count_d;
    end
  end

  // NOTE: the storage array has no reset; the head is masked to zero while
  // the count is zero, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[wr_ptr_q] <= bus.iRD_DATA;
  end

  assign bus.oACT_RD_n = act_rd_n_q;
  assign bus.oACT_WR_n = act_wr_n_q;
  assign bus.oBUS_OE   = bus_oe_q;
  assign bus.oWR_DATA  = wr_data_q;
  assign bus.oTX_READY = !tx_full_q;
  assign bus.oRX_VALID = (rx_count_q != '0);
  assign bus.oRX_DATA  = (rx_count_q != '0) ? rx_mem[rd_ptr_q] : 8'h00;
endmodule

// File: tb/tb_ftdi_fifo_arb.sv
// tb_ftdi_fifo_arb
// Self-checking bench for ftdi_fifo_arb. Behavioural read/write sequencer
// responders and a queue-based model of the RX FIFO, TX holding register
// and bus direction run inside step(), one call per clock.
module tb_ftdi_fifo_arb;
  localparam int RX_AW    = 2;
  localparam int TURN_CYC = 2;
  localparam int DEPTH    = 1 << RX_AW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #10 clk = ~clk;

  ftdi_fifo_arb_if bus();
  ftdi_fifo_arb #(.RX_AW(RX_AW), .TURN_CYC(TURN_CYC)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0, failures = 0, cyc = 0;

  // model state
  logic [7:0] rd_src[$], rx_model[$], popped[$];
  bit         oe_hist[$];
  logic [7:0] rd_cur, push_val, txacc_val, tx_data_m, tx_offer_data;
  bit push_pend, pop_pend, txacc_pend, txclr_pend, tx_full_m;
  bit rd_busy, wr_busy, last_dir_wr_m, prev_act_rd, prev_act_wr;
  int rd_wait, wr_wait, last_done_cyc, last_act_side, last_act_cyc;
  int rd_acts, wr_acts, rd_dones, wr_dones;
  // knobs
  bit exact_gap, alt_check, tx_stream, tx_offer, stray_rd, stray_wr;
  int ready_mode; // 0 low, 1 high, 2 random, 3 only with a read done
  int wr_delay_fix;

  task automatic model_reset();
    rx_model.delete(); oe_hist.delete();
    push_pend = 0; pop_pend = 0; txacc_pend = 0; txclr_pend = 0;
    tx_full_m = 0; tx_data_m = 8'h00;
    rd_busy = 0; wr_busy = 0; last_dir_wr_m = 0; prev_act_rd = 0; prev_act_wr = 0;
    last_done_cyc = -1; last_act_side = -1; last_act_cyc = -1;
    tx_offer = 0; tx_stream = 0; stray_rd = 0; stray_wr = 0;
    bus.iDONE_RD_n = 1'b1; bus.iDONE_WR_n = 1'b1; bus.iTX_VALID = 1'b0;
  endtask

  task automatic clear_counts();
    rd_acts = 0; wr_acts = 0; rd_dones = 0; wr_dones = 0;
  endtask

  task automatic step();
    bit is_wr, chg;
    int gap_exp;
    @(negedge clk);
    cyc++;
    // commit what the DUT took at the last rising edge
    if (pop_pend)   begin void'(rx_model.pop_front()); pop_pend = 0; end
    if (push_pend)  begin rx_model.push_back(push_val); push_pend = 0; end
    if (txacc_pend) begin tx_full_m = 1; tx_data_m = txacc_val; txacc_pend = 0; end
    if (txclr_pend) begin tx_full_m = 0; txclr_pend = 0; end

    checks++;
    if (bus.oRX_VALID !== (rx_model.size() != 0)) begin
      failures++; $display("FAIL rx_valid @%0d: got %b want %b", cyc, bus.oRX_VALID, rx_model.size() != 0);
    end
    if (rx_model.size() != 0) begin
      checks++;
      if (bus.oRX_DATA !== rx_model[0]) begin
        failures++; $display("FAIL rx_head @%0d: got %h want %h", cyc, bus.oRX_DATA, rx_model[0]);
      end
    end
    checks++;
    if (bus.oTX_READY !== !tx_full_m) begin
      failures++; $display("FAIL tx_ready @%0d: got %b want %b", cyc, bus.oTX_READY, !tx_full_m);
    end
    checks++;
    if (bus.oWR_DATA !== tx_data_m) begin
      failures++; $display("FAIL wr_data @%0d: got %h want %h", cyc, bus.oWR_DATA, tx_data_m);
    end
    checks++;
    if (!bus.oACT_RD_n && !bus.oACT_WR_n) begin
      failures++; $display("FAIL act_both @%0d: got both activates low want at most one", cyc);
    end

    bus.iDONE_RD_n = 1'b1;
    bus.iDONE_WR_n = 1'b1;
    if (stray_rd && !rd_busy) begin bus.iDONE_RD_n = 1'b0; bus.iRD_DATA = 8'hEE; end
    if (stray_wr && !wr_busy) bus.iDONE_WR_n = 1'b0;

    // read sequencer responder
    if (rd_busy) begin
      checks++;
      if (bus.oBUS_OE !== 1'b0) begin
        failures++; $display("FAIL oe_during_read @%0d: got %b want 0", cyc, bus.oBUS_OE);
      end
      rd_wait--;
      if (rd_wait == 0) begin
        rd_busy = 0; bus.iDONE_RD_n = 1'b0; bus.iRD_DATA = rd_cur;
        push_pend = 1; push_val = rd_cur; rd_dones++; last_done_cyc = cyc;
      end
    end
    // write sequencer responder
    if (wr_busy) begin
      checks++;
      if (bus.oBUS_OE !== 1'b1) begin
        failures++; $display("FAIL oe_during_write @%0d: got %b want 1", cyc, bus.oBUS_OE);
      end
      wr_wait--;
      if (wr_wait == 0) begin
        wr_busy = 0; bus.iDONE_WR_n = 1'b0; txclr_pend = 1; wr_dones++; last_done_cyc = cyc;
      end
    end

    // activate detection
    if (!bus.oACT_RD_n || !bus.oACT_WR_n) begin
      is_wr = !bus.oACT_WR_n;
      checks++;
      if ((is_wr && prev_act_wr) || (!is_wr && prev_act_rd)) begin
        failures++; $display("FAIL act_width @%0d: got %s activate low 2+ cycles want 1", cyc, is_wr ? "WR" : "RD");
      end else begin
        chg = (is_wr != last_dir_wr_m);
        checks++;
        if (is_wr && (!tx_full_m || bus.oBUS_OE !== 1'b1)) begin
          failures++; $display("FAIL wr_grant @%0d: got tx_full=%b oe=%b want 1 1", cyc, tx_full_m, bus.oBUS_OE);
        end else if (!is_wr && (rd_src.size() == 0 || rx_model.size() >= DEPTH || bus.oBUS_OE !== 1'b0)) begin
          failures++; $display("FAIL rd_grant @%0d: got src=%0d count=%0d oe=%b want >0 <%0d 0",
                               cyc, rd_src.size(), rx_model.size(), bus.oBUS_OE, DEPTH);
        end
        if (chg && oe_hist.size() >= TURN_CYC + 1) begin
          checks++;
          for (int i = 1; i <= TURN_CYC; i++) begin
            if (oe_hist[oe_hist.size() - i] !== 1'b0) begin
              failures++; $display("FAIL turn_oe @%0d: got oe=1 %0d cycles before ACT want 0", cyc, i);
              break;
            end
          end
          if (!is_wr) begin
            checks++;
            if (oe_hist[oe_hist.size() - TURN_CYC - 1] !== 1'b1) begin
              failures++; $display("FAIL turn_len @%0d: got oe=0 before turnaround want 1 (idle after write)", cyc);
            end
          end
        end
        if (exact_gap && last_done_cyc >= 0) begin
          gap_exp = 2 + (chg ? TURN_CYC : 0);
          checks++;
          if (cyc - last_done_cyc != gap_exp) begin
            failures++; $display("FAIL grant_gap @%0d: got %0d want %0d", cyc, cyc - last_done_cyc, gap_exp);
          end
        end
        if (alt_check && last_act_side >= 0) begin
          checks++;
          if (int'(is_wr) == last_act_side) begin
            failures++; $display("FAIL round_robin @%0d: got %s twice want alternation", cyc, is_wr ? "WR" : "RD");
          end
        end
        last_dir_wr_m = is_wr; last_act_side = int'(is_wr); last_act_cyc = cyc;
        if (is_wr) begin
          wr_busy = 1; wr_wait = (wr_delay_fix > 0) ? wr_delay_fix : int'($urandom_range(1, 3)); wr_acts++;
        end else begin
          rd_busy = 1; rd_wait = $urandom_range(1, 3); rd_acts++;
          rd_cur = (rd_src.size() != 0) ? rd_src.pop_front() : 8'($urandom);
        end
      end
    end

    bus.iFIFO_RXF_n = (rd_src.size() == 0);

    // inner-logic consumer
    case (ready_mode)
      0: bus.iRX_READY = 1'b0;
      1: bus.iRX_READY = 1'b1;
      2: bus.iRX_READY = 1'($urandom_range(0, 1));
      default: bus.iRX_READY = !bus.iDONE_RD_n;
    endcase
    if (bus.oRX_VALID && bus.iRX_READY && rx_model.size() != 0) begin
      pop_pend = 1; popped.push_back(bus.oRX_DATA);
    end

    // inner-logic producer
    if (tx_stream) begin
      bus.iTX_VALID = 1'b1; bus.iTX_DATA = 8'($urandom);
    end else if (tx_offer) begin
      bus.iTX_VALID = 1'b1; bus.iTX_DATA = tx_offer_data;
    end else begin
      bus.iTX_VALID = 1'b0;
    end
    if (bus.iTX_VALID && !tx_full_m) begin
      txacc_pend = 1; txacc_val = bus.iTX_DATA; tx_offer = 0;
    end

    oe_hist.push_back(bus.oBUS_OE);
    if (oe_hist.size() > 8) void'(oe_hist.pop_front());
    prev_act_rd = !bus.oACT_RD_n;
    prev_act_wr = !bus.oACT_WR_n;
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (bus.oACT_RD_n !== 1'b1 || bus.oACT_WR_n !== 1'b1 || bus.oBUS_OE !== 1'b0) begin
      failures++; $display("FAIL %s_ctrl: got act_rd=%b act_wr=%b oe=%b want 1 1 0", tag, bus.oACT_RD_n, bus.oACT_WR_n, bus.oBUS_OE);
    end
    checks++;
    if (bus.oRX_VALID !== 1'b0 || bus.oRX_DATA !== 8'h00) begin
      failures++; $display("FAIL %s_rx: got valid=%b data=%h want 0 00", tag, bus.oRX_VALID, bus.oRX_DATA);
    end
    checks++;
    if (bus.oTX_READY !== 1'b1 || bus.oWR_DATA !== 8'h00) begin
      failures++; $display("FAIL %s_tx: got ready=%b wr_data=%h want 1 00", tag, bus.oTX_READY, bus.oWR_DATA);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #25;
    check_reset_outputs("reset");
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step();
  endtask

  task automatic test_read_burst();
    logic [7:0] exp_b [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    clear_counts(); popped.delete();
    ready_mode = 0; bus.iFIFO_TXE_n = 1'b1;
    rd_src = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    for (int i = 0; i < 80 && rd_dones < 4; i++) step();
    for (int i = 0; i < 10; i++) step();
    checks++;
    if (rd_acts != 4 || rd_dones != 4) begin
      failures++; $display("FAIL burst_full: got acts=%0d dones=%0d want 4 4", rd_acts, rd_dones);
    end
    checks++;
    if (bus.oRX_VALID !== 1'b1 || bus.oRX_DATA !== 8'h11) begin
      failures++; $display("FAIL burst_head: got valid=%b data=%h want 1 11", bus.oRX_VALID, bus.oRX_DATA);
    end
    ready_mode = 1; step(); ready_mode = 0;
    for (int i = 0; i < 40 && rd_dones < 5; i++) step();
    checks++;
    if (rd_acts != 5 || rd_dones != 5) begin
      failures++; $display("FAIL burst_resume: got acts=%0d dones=%0d want 5 5", rd_acts, rd_dones);
    end
    ready_mode = 1;
    for (int i = 0; i < 8; i++) step();
    ready_mode = 0;
    checks++;
    if (popped.size() != 5) begin
      failures++; $display("FAIL burst_order: got %0d bytes want 5", popped.size());
    end else begin
      for (int i = 0; i < 5; i++) if (popped[i] !== exp_b[i]) begin
        failures++; $display("FAIL burst_order: byte %0d got %h want %h", i, popped[i], exp_b[i]);
        break;
      end
    end
  endtask

  task automatic test_single_tx();
    int acc_cyc;
    clear_counts(); ready_mode = 0; bus.iFIFO_TXE_n = 1'b0; wr_delay_fix = 0;
    tx_offer_data = 8'h3C; tx_offer = 1;
    for (int i = 0; i < 40 && wr_dones < 1; i++) step();
    step();
    checks++;
    if (wr_dones != 1 || bus.oBUS_OE !== 1'b1) begin
      failures++; $display("FAIL tx_first: got dones=%0d oe=%b want 1 1", wr_dones, bus.oBUS_OE);
    end
    tx_offer_data = 8'hA5; tx_offer = 1;
    step(); acc_cyc = cyc;
    step();
    checks++;
    if (bus.oTX_READY !== 1'b0 || bus.oWR_DATA !== 8'hA5) begin
      failures++; $display("FAIL tx_accept: got ready=%b data=%h want 0 a5", bus.oTX_READY, bus.oWR_DATA);
    end
    for (int i = 0; i < 20 && wr_acts < 2; i++) step();
    checks++;
    if (wr_acts != 2 || last_act_cyc != acc_cyc + 2) begin
      failures++; $display("FAIL tx_latency: got acts=%0d act_at=+%0d want 2 +2", wr_acts, last_act_cyc - acc_cyc);
    end
    for (int i = 0; i < 20 && wr_dones < 2; i++) step();
    step();
    checks++;
    if (bus.oTX_READY !== 1'b1 || bus.oBUS_OE !== 1'b1 || bus.oWR_DATA !== 8'hA5) begin
      failures++; $display("FAIL tx_done: got ready=%b oe=%b data=%h want 1 1 a5", bus.oTX_READY, bus.oBUS_OE, bus.oWR_DATA);
    end
  endtask

  task automatic test_contention();
    clear_counts();
    for (int i = 0; i < 24; i++) rd_src.push_back(8'($urandom));
    ready_mode = 1; bus.iFIFO_TXE_n = 1'b0; tx_stream = 1;
    last_done_cyc = -1; last_act_side = -1; exact_gap = 1; alt_check = 1;
    for (int i = 0; i < 400 && (rd_dones + wr_dones) < 8; i++) step();
    exact_gap = 0; alt_check = 0; tx_stream = 0; rd_src.delete();
    checks++;
    if (rd_acts < 4 || wr_acts < 4) begin
      failures++; $display("FAIL contention: got rd=%0d wr=%0d want >=4 each", rd_acts, wr_acts);
    end
    for (int i = 0; i < 40; i++) step();
    checks++;
    if (rd_busy || wr_busy || bus.oTX_READY !== 1'b1) begin
      failures++; $display("FAIL contention_drain: got busy=%b%b tx_ready=%b want 00 1", rd_busy, wr_busy, bus.oTX_READY);
    end
    bus.iFIFO_TXE_n = 1'b1; ready_mode = 0;
  endtask

  task automatic test_push_pop();
    logic [7:0] exp_b [3] = '{8'h61, 8'h62, 8'h63};
    clear_counts(); popped.delete(); ready_mode = 0;
    rd_src = '{8'h61, 8'h62};
    for (int i = 0; i < 40 && rd_dones < 2; i++) step();
    step();
    rd_src.push_back(8'h63); ready_mode = 3;
    for (int i = 0; i < 40 && rd_dones < 3; i++) step();
    ready_mode = 0;
    step(); step();
    checks++;
    if (bus.oRX_VALID !== 1'b1 || bus.oRX_DATA !== 8'h62) begin
      failures++; $display("FAIL pushpop_head: got valid=%b data=%h want 1 62", bus.oRX_VALID, bus.oRX_DATA);
    end
    ready_mode = 1;
    for (int i = 0; i < 6; i++) step();
    ready_mode = 0;
    checks++;
    if (popped.size() != 3 || bus.oRX_VALID !== 1'b0) begin
      failures++; $display("FAIL pushpop_count: got %0d bytes valid=%b want 3 0", popped.size(), bus.oRX_VALID);
    end else begin
      for (int i = 0; i < 3; i++) if (popped[i] !== exp_b[i]) begin
        failures++; $display("FAIL pushpop_order: byte %0d got %h want %h", i, popped[i], exp_b[i]);
        break;
      end
    end
  endtask

  task automatic test_stray_done();
    clear_counts(); ready_mode = 0; bus.iFIFO_TXE_n = 1'b1;
    tx_offer_data = 8'h5A; tx_offer = 1;
    for (int i = 0; i < 3; i++) step();
    stray_wr = 1; step(); stray_wr = 0;
    stray_rd = 1; step(); stray_rd = 0;
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (bus.oTX_READY !== 1'b0 || bus.oRX_VALID !== 1'b0 || rd_acts != 0 || wr_acts != 0) begin
      failures++; $display("FAIL stray_done: got tx_ready=%b rx_valid=%b acts=%0d/%0d want 0 0 0/0",
                           bus.oTX_READY, bus.oRX_VALID, rd_acts, wr_acts);
    end
    bus.iFIFO_TXE_n = 1'b0;
    for (int i = 0; i < 30 && wr_dones < 1; i++) step();
    step();
    checks++;
    if (wr_dones != 1 || bus.oTX_READY !== 1'b1) begin
      failures++; $display("FAIL stray_recover: got dones=%0d tx_ready=%b want 1 1", wr_dones, bus.oTX_READY);
    end
    bus.iFIFO_TXE_n = 1'b1;
  endtask

  task automatic test_reset_mid();
    clear_counts(); ready_mode = 0;
    rd_src = '{8'h77};
    for (int i = 0; i < 40 && rd_dones < 1; i++) step();
    step();
    bus.iFIFO_TXE_n = 1'b0; wr_delay_fix = 8;
    tx_offer_data = 8'hAA; tx_offer = 1;
    for (int i = 0; i < 40 && wr_acts < 1; i++) step();
    step(); step();
    checks++;
    if (bus.oBUS_OE !== 1'b1 || bus.oRX_VALID !== 1'b1 || !wr_busy) begin
      failures++; $display("FAIL midreset_setup: got oe=%b rx_valid=%b busy=%b want 1 1 1", bus.oBUS_OE, bus.oRX_VALID, wr_busy);
    end
    #3 rst = 1'b0;
    #1 check_reset_outputs("midreset");
    model_reset(); wr_delay_fix = 0; bus.iFIFO_TXE_n = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) step();
  endtask

  initial begin
    bus.iRX_READY = 1'b0; bus.iTX_DATA = 8'h00; bus.iTX_VALID = 1'b0;
    bus.iREADY_RD_n = 1'b0; bus.iDONE_RD_n = 1'b1; bus.iRD_DATA = 8'h00;
    bus.iREADY_WR_n = 1'b0; bus.iDONE_WR_n = 1'b1;
    bus.iFIFO_RXF_n = 1'b1; bus.iFIFO_TXE_n = 1'b1;
    ready_mode = 0; wr_delay_fix = 0; exact_gap = 0; alt_check = 0;
    clear_counts();
    test_reset();
    test_read_burst();
    test_single_tx();
    test_contention();
    test_push_pop();
    test_stray_done();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached before the summary");
    $fatal(1, "watchdog");
  end
endmodule
